// File: rtl/hex_entry_pkg.sv
// Shared constants, input bit map and action encoding for the hex entry front end.
// Pure declarations; no logic, no latency, no flow control.
package hex_entry_pkg;

    localparam int NDIG_MAX      = 8;
    localparam int DB_TICKS_DFLT = 200_000;

    // Debounced input vector layout: switches in [15:0], then the three buttons.
    localparam int N_IN    = 19;
    localparam int IDX_DEL = 16;
    localparam int IDX_CLR = 17;
    localparam int IDX_ENT = 18;

    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_CLR  = 3'd1,
        ACT_DEL  = 3'd2,
        ACT_ENT  = 3'd3,
        ACT_DIG  = 3'd4
    } act_e;

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_entry_debouncer.sv
// Two-flop synchronizer plus tick-sampled debounce for N raw inputs, one shared prescaler.
// Latency: 2 cycles to sync, then 1-2 ticks to db; free-running, no backpressure.
module debouncer
    import hex_entry_pkg::*;
#(
    parameter int N        = N_IN,
    parameter int DB_TICKS = DB_TICKS_DFLT,
    parameter int DB_W     = 18
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_raw,
    output logic [N-1:0] o_sync,
    output logic [N-1:0] o_db
);

    logic [N-1:0]    r_s1;
    logic [N-1:0]    r_s2;
    logic [N-1:0]    r_smp;
    logic [N-1:0]    r_db;
    logic [DB_W-1:0] r_cnt;
    logic            w_tick;
    logic [N-1:0]    w_eq;

    assign w_tick = (r_cnt == DB_W'(DB_TICKS - 1));
    // A bit is accepted only when it matches the value seen on the previous tick.
    assign w_eq   = ~(r_s2 ^ r_smp);

    always_ff @(posedge clk) begin
        r_s1 <= i_raw;
        r_s2 <= r_s1;
        if (rst) begin
            r_cnt <= '0;
            r_smp <= r_s2;
            r_db  <= r_s2;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_smp <= r_s2;
                r_db  <= (r_db & ~w_eq) | (r_s2 & w_eq);
            end
        end
    end

    assign o_sync = r_s2;
    assign o_db   = r_db;

endmodule

// File: rtl/hex_entry.sv
// Hex digit entry: debounced switches/buttons drive a shifting 8-digit entry and a commit strobe.
// Latency: outputs update one clk after the debounced edge; no backpressure, events can be dropped.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DFLT,
    parameter int DB_W     = 18
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btn_del,
    input  logic        btn_clr,
    input  logic        btn_ent,
    output logic [31:0] d,
    output logic [3:0]  ndig,
    output logic [31:0] dout,
    output logic        dout_vld
);

    logic [N_IN-1:0] w_raw;
    logic [N_IN-1:0] w_sync;
    logic [N_IN-1:0] w_db;
    logic [N_IN-1:0] r_db_q;
    logic [15:0]     w_sw_ev;
    logic            w_del_ev;
    logic            w_clr_ev;
    logic            w_ent_ev;
    act_e            w_act;
    logic [3:0]      w_idx;

    logic [31:0]     r_d;
    logic [3:0]      r_ndig;
    logic [31:0]     r_dout;
    logic            r_dout_vld;

    assign w_raw = {btn_ent, btn_clr, btn_del, sw};

    debouncer #(
        .N        (N_IN),
        .DB_TICKS (DB_TICKS),
        .DB_W     (DB_W)
    ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (w_raw),
        .o_sync (w_sync),
        .o_db   (w_db)
    );

    assign w_sw_ev  = w_db[15:0] ^ r_db_q[15:0];
    assign w_del_ev = w_db[IDX_DEL] & ~r_db_q[IDX_DEL];
    assign w_clr_ev = w_db[IDX_CLR] & ~r_db_q[IDX_CLR];
    assign w_ent_ev = w_db[IDX_ENT] & ~r_db_q[IDX_ENT];

    always_comb begin
        w_act = ACT_NONE;
        w_idx = lowest_idx(w_sw_ev);
        if (w_clr_ev)      w_act = ACT_CLR;
        else if (w_del_ev) w_act = ACT_DEL;
        else if (w_ent_ev) w_act = ACT_ENT;
        else if (|w_sw_ev) w_act = ACT_DIG;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // db reloads from the synchronizer during reset, so seed the edge register the same way.
            r_db_q     <= w_sync;
            r_d        <= '0;
            r_ndig     <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_db_q     <= w_db;
            r_dout_vld <= 1'b0;
            case (w_act)
                ACT_CLR: begin
                    r_d    <= '0;
                    r_ndig <= '0;
                end
                ACT_DEL: begin
                    r_d <= {4'h0, r_d[31:4]};
                    if (r_ndig != 4'd0) r_ndig <= r_ndig - 4'd1;
                end
                ACT_ENT: begin
                    r_dout     <= r_d;
                    r_dout_vld <= 1'b1;
                end
                ACT_DIG: begin
                    r_d <= {r_d[27:0], w_idx};
                    if (r_ndig < 4'(NDIG_MAX)) r_ndig <= r_ndig + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign d        = r_d;
    assign ndig     = r_ndig;
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;

endmodule

// File: tb/tb_hex_entry.sv
// Directed bench for hex_entry with a digit-queue reference model and per-cycle comparison.
module tb_hex_entry;

    localparam int TICKS  = 4;
    localparam int SETTLE = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw = '0;
    logic        btn_del = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_ent = 1'b0;
    logic [31:0] d;
    logic [3:0]  ndig;
    logic [31:0] dout;
    logic        dout_vld;

    hex_entry #(.DB_TICKS(TICKS), .DB_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .btn_del  (btn_del),
        .btn_clr  (btn_clr),
        .btn_ent  (btn_ent),
        .d        (d),
        .ndig     (ndig),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          digs[$];
    logic [31:0] m_dout = '0;
    int          m_vld = 0;
    int          vld_seen = 0;
    bit          settled = 1'b0;

    // Reference model: the entry is just the ordered list of the last 8 digits typed.
    function automatic logic [31:0] m_d();
        logic [31:0] v;
        v = '0;
        foreach (digs[k]) v = (v << 4) | 32'(digs[k]);
        return v;
    endfunction

    task automatic m_dig(input int i);
        digs.push_back(i);
        if (digs.size() > 8) void'(digs.pop_front());
    endtask

    task automatic m_del();
        if (digs.size() > 0) void'(digs.pop_back());
    endtask

    task automatic m_ent();
        m_dout = m_d();
        m_vld++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (dout_vld === 1'b1) vld_seen++;
    end

    always @(negedge clk) begin
        if (settled) begin
            check("d", d, m_d());
            check("ndig", {28'd0, ndig}, 32'(digs.size()));
            check("dout", dout, m_dout);
            check("dout_vld_idle", {31'd0, dout_vld}, 32'd0);
            check("vld_pulses", 32'(vld_seen), 32'(m_vld));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle(input int i);
        settled = 1'b0;
        sw[i] = ~sw[i];
        cyc(SETTLE);
        m_dig(i);
        settled = 1'b1;
    endtask

    // Buttons: {ent, clr, del}; held to settle, then released and held again.
    task automatic press(input logic [2:0] b);
        settled = 1'b0;
        {btn_ent, btn_clr, btn_del} = b;
        cyc(SETTLE);
        if (b[1])      digs.delete();
        else if (b[0]) m_del();
        else if (b[2]) m_ent();
        settled = 1'b1;
        {btn_ent, btn_clr, btn_del} = 3'b000;
        cyc(SETTLE);
    endtask

    task automatic lits(input string tag, input logic [31:0] ed, input int en, input logic [31:0] edout);
        check({tag, "_d"}, d, ed);
        check({tag, "_ndig"}, {28'd0, ndig}, 32'(en));
        check({tag, "_dout"}, dout, edout);
    endtask

    initial begin
        logic orig;
        logic fin;

        cyc(6);
        lits("reset", 32'h0, 0, 32'h0);
        check("reset_vld", {31'd0, dout_vld}, 32'd0);
        rst = 1'b0;
        settled = 1'b1;
        cyc(5);

        // 1: three digits
        toggle(3); toggle(10); toggle(15);
        lits("t1", 32'h0000_03AF, 3, 32'h0);
        check("t1_vld", 32'(vld_seen), 32'd0);

        // 2: overflow and delete
        for (int i = 1; i <= 9; i++) toggle(i);
        lits("t2_fill", 32'h2345_6789, 8, 32'h0);
        press(3'b001);
        press(3'b001);
        lits("t2_del", 32'h0023_4567, 6, 32'h0);

        // 3: commit then clear
        press(3'b010);
        toggle(10); toggle(11);
        lits("t3_pre", 32'h0000_00AB, 2, 32'h0);
        press(3'b100);
        lits("t3_ent", 32'h0000_00AB, 2, 32'h0000_00AB);
        check("t3_vld", 32'(vld_seen), 32'd1);
        press(3'b010);
        lits("t3_clr", 32'h0, 0, 32'h0000_00AB);

        // 4: short glitch rejected, bounce yields one digit
        sw[5] = ~sw[5];
        cyc(3);
        sw[5] = ~sw[5];
        cyc(SETTLE);
        lits("t4_glitch", 32'h0, 0, 32'h0000_00AB);
        settled = 1'b0;
        orig = sw[5];
        fin  = ~sw[5];
        for (int k = 0; k < 10; k++) begin
            sw[5] = (k % 3 == 2) ? orig : fin;
            cyc(1);
        end
        sw[5] = fin;
        cyc(SETTLE);
        m_dig(5);
        settled = 1'b1;
        cyc(SETTLE);
        lits("t4_bounce", 32'h0000_0005, 1, 32'h0000_00AB);

        // 5: simultaneous events
        settled = 1'b0;
        sw[2] = ~sw[2];
        sw[7] = ~sw[7];
        cyc(SETTLE);
        m_dig(2);
        settled = 1'b1;
        lits("t5_two", 32'h0000_0052, 2, 32'h0000_00AB);
        toggle(7);
        lits("t5_seven", 32'h0000_0527, 3, 32'h0000_00AB);
        press(3'b011);
        lits("t5_clrdel", 32'h0, 0, 32'h0000_00AB);
        press(3'b001);
        lits("t5_del_empty", 32'h0, 0, 32'h0000_00AB);

        // 6: reset mid-entry and mid-debounce
        toggle(1); toggle(2); toggle(3); toggle(4);
        lits("t6_pre", 32'h0000_1234, 4, 32'h0000_00AB);
        settled = 1'b0;
        sw[6] = ~sw[6];
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        digs.delete();
        m_dout = '0;
        settled = 1'b1;
        cyc(40);
        lits("t6_post", 32'h0, 0, 32'h0);
        check("t6_vld", 32'(vld_seen), 32'd1);

        settled = 1'b0;
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_entry.md
Name: hex_entry

Overview:
- Operator-input front end for the lab boards: turns 16 hex-digit switches and 3 push-buttons into a 32-bit hex value.
- Output d drives the 8-digit dynamic seven-segment display directly, so the value being typed is shown live.
- Enter latches the value to dout with a one-cycle dout_vld strobe for downstream datapaths (register file, memory debug port, etc.).

Parameters:
- DB_TICKS, 200_000, clk cycles between debounce samples (2 ms at 100 MHz); benches use 4.
- DB_W, 18, width of the debounce prescaler counter; must satisfy 2^DB_W > DB_TICKS.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sw  input  16  raw slide switches; toggling sw[i] (either direction) enters hex digit i
- btn_del  input  1  raw button; removes the most recently entered digit
- btn_clr  input  1  raw button; clears the entry
- btn_ent  input  1  raw button; commits the entry
- d  output  32  current entry, least recent digit in the upper nibbles, newest digit in d[3:0]
- ndig  output  4  number of digits entered, 0..8
- dout  output  32  last committed value
- dout_vld  output  1  one-cycle pulse when dout is updated

Behaviour:
- Reset (rst=1 at a clk edge): d=0, ndig=0, dout=0, dout_vld=0, prescaler=0.
  - Synchronizers, sample and debounced registers load the current synchronized input values, so no edges occur after reset.
  - Reset mid-debounce or mid-entry discards everything.
- Synchronizer: all 19 raw inputs pass through 2 flip-flop stages before any use.
- Prescaler: counts 0..DB_TICKS-1 and wraps; tick=1 for one cycle when count==DB_TICKS-1.
- Debounce, per input, on a tick only:
  - smp <= sync.
  - If sync==smp, db <= sync.
  - A level is therefore accepted after it is seen on 2 consecutive ticks; a glitch shorter than DB_TICKS never reaches db.
- Edge detect: db_q <= db every cycle.
  - Switch event: sw_db != sw_db_q (any direction).
  - Button event: db=1 and db_q=0 (press only; release is ignored).
- Action, at most one per cycle, in priority order:
  1. clr: d=0, ndig=0.
  2. del: d <= {4'h0, d[31:4]}; ndig <= ndig-1, saturating at 0. Deleting with ndig=0 leaves d=0.
  3. ent: dout <= d; dout_vld=1 next cycle for exactly one cycle. d and ndig are unchanged.
  4. Switch: lowest changed index i wins; d <= {d[27:0], i[3:0]}; ndig <= min(ndig+1, 8).
     - With ndig=8 the top digit is shifted out (wrap-around discard).
- Lost events:
  - Lower-priority events in the same cycle are lost.
  - Simultaneous switch events on other indices are lost; their db still updates.
  - Higher-priority actions are never lost.
- Latency:
  - Raw change to db: 2 sync cycles, then 1 to 2 ticks.
  - d, ndig and dout update on the clk edge after the cycle in which db changes.
- Outputs are registered; there are no combinational paths from raw inputs to outputs.

Decomposition:
- Shared package hex_entry_pkg holds:
  - NDIG_MAX=8
  - action encoding ACT_NONE/ACT_CLR/ACT_DEL/ACT_ENT/ACT_DIG (3 bits)
  - the default DB_TICKS constant
- Sub-module debouncer #(.N, .DB_TICKS, .DB_W) contains the synchronizer, shared prescaler and per-bit sample/db registers. It outputs db[N-1:0] and is instantiated once with N=19.
- The top level holds the edge detect, priority encoder, and d/ndig/dout registers.

Test Plan (DB_TICKS=4):
1. Reset, then toggle sw[3], sw[10], sw[15] in turn, each held 20 cycles -> d=32'h0000_03AF, ndig=3, dout_vld never asserted.
2. Enter 9 digits 1,2,…,9 -> d=32'h2345_6789, ndig=8. Press btn_del twice -> d=32'h0023_4567, ndig=6.
3. With d=32'h0000_00AB, press btn_ent -> exactly one dout_vld pulse, dout=32'h0000_00AB, d unchanged. Then press btn_clr -> d=0, ndig=0, dout stays 32'h0000_00AB.
4. Pulse sw[5] for 3 cycles, shorter than one tick interval -> no change to d or ndig. Apply 10 cycles of 1/0 bounce followed by a stable level -> exactly one digit 5 entered.
5. Toggle sw[2] and sw[7] in the same cycle -> only digit 2 entered, ndig+1. A later toggle of sw[7] alone enters 7. Press btn_clr and btn_del in the same cycle -> d=0, ndig=0.
6. Assert rst for 1 cycle during a debounce in progress and with ndig=4 -> all outputs 0. Holding switches static afterwards produces no spurious entry.
